// File: rtl/component_tracker_mp.sv
// component_tracker_mp: per-antenna/per-pol S+/S- window accumulation with double-buffered baseline correction lookup
// ports: clk, rst_n (sync active-low), sync (window start), din (N_POLS*P samples of {re,im});
//        req_vld/req_ant_a/req_ant_b/req_pol_a/req_pol_b -> corr_vld/re_corr/im_corr;
//        rd_bank/bank_vld (served bank status), window_done (bank switch pulse)
// COMPONENT_TRACKER_MP_DOUT_REG_EN: extra output register, request latency 3 instead of 2
module component_tracker_mp #(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int P_FACTOR_BITS = 2,
  parameter int BITWIDTH = 4,
  parameter int N_ANTS = 32,
  parameter int N_POLS = 2,
  localparam int B = BITWIDTH,
  localparam int P = 1 << P_FACTOR_BITS,
  localparam int ADD_W = P_FACTOR_BITS + B,
  localparam int SUM_W = ADD_W + 2,
  localparam int ACC_W = SUM_W + SERIAL_ACC_LEN_BITS,
  localparam int CORR_W = ACC_W + 1,
  localparam int AB = $clog2(N_ANTS),
  localparam int PB = N_POLS > 1 ? $clog2(N_POLS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sync,
  input  logic [N_POLS*P*2*B-1:0]  din,
  input  logic                     req_vld,
  input  logic [AB-1:0]            req_ant_a,
  input  logic [AB-1:0]            req_ant_b,
  input  logic [PB-1:0]            req_pol_a,
  input  logic [PB-1:0]            req_pol_b,
  output logic                     corr_vld,
  output logic signed [CORR_W-1:0] re_corr,
  output logic signed [CORR_W-1:0] im_corr,
  output logic                     rd_bank,
  output logic                     bank_vld,
  output logic                     window_done
);
  logic run, wr_bank, v1, f1, l1, w1, sw;
  logic [SERIAL_ACC_LEN_BITS-1:0] cnt;
  logic [AB-1:0] ant, a1;
  logic [ADD_W-1:0] re_t [N_POLS], re_s [N_POLS];
  logic signed [ADD_W-1:0] im_t [N_POLS], im_s [N_POLS];
  logic signed [SUM_W-1:0] sp [N_POLS], sm [N_POLS];
  logic signed [ACC_W-1:0] ap [N_POLS], am [N_POLS], ap_n [N_POLS], am_n [N_POLS];
  logic [N_POLS*ACC_W-1:0] wp, wm;
  logic [N_POLS*ACC_W-1:0] mp [2*N_ANTS], mm [2*N_ANTS];
  logic qv, qbank;
  logic [AB-1:0] qa, qb;
  logic [PB-1:0] qpa, qpb;
  logic signed [ACC_W-1:0] spa, spb, sma, smb;
  logic signed [CORR_W-1:0] rc, ic;
  function automatic logic signed [ACC_W-1:0] sel(input logic [N_POLS*ACC_W-1:0] w, input logic [PB-1:0] p);
    sel = '0;
    for (int i = 0; i < N_POLS; i++) if (p == PB'(i)) sel = w[i*ACC_W +: ACC_W];
  endfunction
  // adder tree input: re made offset-binary by flipping its sign bit
  always_comb begin
    for (int p = 0; p < N_POLS; p++) begin
      re_t[p] = '0;
      im_t[p] = '0;
      for (int i = 0; i < P; i++) begin
        re_t[p] = re_t[p] + ADD_W'({~din[(p*P+i)*2*B+2*B-1], din[(p*P+i)*2*B+B +: B-1]});
        im_t[p] = im_t[p] + ADD_W'($signed(din[(p*P+i)*2*B +: B]));
      end
    end
  end
  always_comb begin
    wp = '0;
    wm = '0;
    for (int p = 0; p < N_POLS; p++) begin
      sp[p] = SUM_W'($signed({1'b0, re_s[p]})) + SUM_W'(im_s[p]);
      sm[p] = SUM_W'($signed({1'b0, re_s[p]})) - SUM_W'(im_s[p]);
      ap_n[p] = f1 ? ACC_W'(sp[p]) : ap[p] + ACC_W'(sp[p]);
      am_n[p] = f1 ? ACC_W'(sm[p]) : am[p] + ACC_W'(sm[p]);
      wp[p*ACC_W +: ACC_W] = ap_n[p];
      wm[p*ACC_W +: ACC_W] = am_n[p];
    end
  end
  always_ff @(posedge clk) begin
    re_s <= re_t;
    im_s <= im_t;
    a1 <= ant;
    f1 <= cnt == '0;
    l1 <= &cnt;
    w1 <= (&cnt) && (ant == AB'(N_ANTS - 1));
    if (v1 && !sync) begin
      ap <= ap_n;
      am <= am_n;
    end
    if (rst_n && v1 && l1 && !sync) begin
      mp[{wr_bank, a1}] <= wp;
      mm[{wr_bank, a1}] <= wm;
    end
    qa <= req_ant_a;
    qb <= req_ant_b;
    qpa <= req_pol_a;
    qpb <= req_pol_b;
    qbank <= rd_bank;
  end
  // sync kills every sample in flight, including a pending bank switch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
      ant <= '0;
      wr_bank <= 1'b0;
      v1 <= 1'b0;
      sw <= 1'b0;
      rd_bank <= 1'b0;
      bank_vld <= 1'b0;
      window_done <= 1'b0;
    end else begin
      v1 <= run && !sync;
      sw <= v1 && l1 && w1 && !sync;
      window_done <= sw && !sync;
      if (sync) begin
        run <= 1'b1;
        cnt <= '0;
        ant <= '0;
        wr_bank <= 1'b0;
        rd_bank <= 1'b0;
        bank_vld <= 1'b0;
      end else begin
        if (run) begin
          cnt <= cnt + 1'b1;
          if (&cnt) ant <= (ant == AB'(N_ANTS - 1)) ? '0 : ant + 1'b1;
        end
        if (sw) begin
          rd_bank <= wr_bank;
          bank_vld <= 1'b1;
          wr_bank <= ~wr_bank;
        end
      end
    end
  end
  always_comb begin
    spa = sel(mp[{qbank, qa}], qpa);
    spb = sel(mp[{qbank, qb}], qpb);
    sma = sel(mm[{qbank, qa}], qpa);
    smb = sel(mm[{qbank, qb}], qpb);
    rc = CORR_W'(spa) + CORR_W'(spb);
    ic = CORR_W'(smb) - CORR_W'(sma);
  end
`ifdef COMPONENT_TRACKER_MP_DOUT_REG_EN
  logic v2;
  logic signed [CORR_W-1:0] r2, i2;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qv <= 1'b0;
      corr_vld <= 1'b0;
      re_corr <= '0;
      im_corr <= '0;
`ifdef COMPONENT_TRACKER_MP_DOUT_REG_EN
      v2 <= 1'b0;
      r2 <= '0;
      i2 <= '0;
`endif
    end else begin
      qv <= req_vld && bank_vld;
`ifdef COMPONENT_TRACKER_MP_DOUT_REG_EN
      v2 <= qv;
      r2 <= qv ? rc : '0;
      i2 <= qv ? ic : '0;
      corr_vld <= v2;
      re_corr <= r2;
      im_corr <= i2;
`else
      corr_vld <= qv;
      re_corr <= qv ? rc : '0;
      im_corr <= qv ? ic : '0;
`endif
    end
  end
endmodule

// File: tb/tb_component_tracker_mp.sv
// tb_component_tracker_mp: randomized scoreboard bench for component_tracker_mp against a window-level reference model
module tb_component_tracker_mp;
  localparam int SAL = 2, PFB = 1, B = 4, NA = 4, NP = 2, L = 4, P = 2, CW = 10;
`ifdef COMPONENT_TRACKER_MP_DOUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic rst_n, sync, req_vld, corr_vld, rd_bank, bank_vld, window_done;
  logic [NP*P*2*B-1:0] din;
  logic [1:0] req_ant_a, req_ant_b;
  logic req_pol_a, req_pol_b;
  logic signed [CW-1:0] re_corr, im_corr;
  component_tracker_mp #(
    .SERIAL_ACC_LEN_BITS(SAL), .P_FACTOR_BITS(PFB), .BITWIDTH(B), .N_ANTS(NA), .N_POLS(NP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .din(din), .req_vld(req_vld),
    .req_ant_a(req_ant_a), .req_ant_b(req_ant_b), .req_pol_a(req_pol_a), .req_pol_b(req_pol_b),
    .corr_vld(corr_vld), .re_corr(re_corr), .im_corr(im_corr),
    .rd_bank(rd_bank), .bank_vld(bank_vld), .window_done(window_done)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int due; bit v; int re; int im;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int mem_p [2][NP][NA], mem_m [2][NP][NA];
  int acc_p [NP][NA], acc_m [NP][NA], pend_p [NP][NA], pend_m [NP][NA];
  int fre [NP][NA], fim [NP][NA];
  bit rnd, mv, mr, wd_exp, running, wb, pend_bank, rst_v;
  int pos = 0, sw_at = -1, clr_at = -1;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d want %0d", n, cyc, a, e);
    end
  endtask
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      chk("bank_vld", bank_vld, mv);
      chk("rd_bank", rd_bank, mr);
      chk("window_done", window_done, wd_exp);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("corr_vld", corr_vld, e.v);
        chk("re_corr", re_corr, e.re);
        chk("im_corr", im_corr, e.im);
      end
    end
  end
  task automatic clr_pat();
    for (int p = 0; p < NP; p++) for (int a = 0; a < NA; a++) begin
      fre[p][a] = 0;
      fim[p][a] = 0;
    end
  endtask
  task automatic step(input bit s, input bit rv, input int aa, input int pa, input int ab, input int pb);
    exp_t e, z;
    int a, r, m;
    @(negedge clk);
    wd_exp = 0;
    if (cyc == clr_at) begin
      mv = 0;
      mr = 0;
    end
    if (cyc == sw_at) begin
      for (int p = 0; p < NP; p++) for (int k = 0; k < NA; k++) begin
        mem_p[pend_bank][p][k] = pend_p[p][k];
        mem_m[pend_bank][p][k] = pend_m[p][k];
      end
      mr = pend_bank;
      mv = 1;
      wd_exp = 1;
    end
    if (!rst_v) for (int i = 0; i < q.size(); i++) if (q[i].due > cyc) begin
      z = q[i];
      z.v = 0;
      z.re = 0;
      z.im = 0;
      q[i] = z;
    end
    e.due = cyc + LAT;
    e.v = rst_v && rv && mv;
    e.re = e.v ? mem_p[mr][pa][aa] + mem_p[mr][pb][ab] : 0;
    e.im = e.v ? mem_m[mr][pb][ab] - mem_m[mr][pa][aa] : 0;
    q.push_back(e);
    rst_n = rst_v;
    sync = s;
    req_vld = rv;
    req_ant_a = 2'(aa);
    req_pol_a = 1'(pa);
    req_ant_b = 2'(ab);
    req_pol_b = 1'(pb);
    din = $urandom;
    if (!rst_v) begin
      running = 0;
      sw_at = -1;
      clr_at = cyc + 1;
      wb = 0;
    end else if (s) begin
      running = 1;
      pos = 0;
      sw_at = -1;
      clr_at = cyc + 1;
      wb = 0;
    end else if (running) begin
      a = pos / L;
      if (pos == 0) for (int p = 0; p < NP; p++) for (int k = 0; k < NA; k++) begin
        acc_p[p][k] = 0;
        acc_m[p][k] = 0;
      end
      for (int p = 0; p < NP; p++) for (int i = 0; i < P; i++) begin
        r = rnd ? int'($urandom_range(0, 15)) - 8 : fre[p][a];
        m = rnd ? int'($urandom_range(0, 15)) - 8 : fim[p][a];
        din[(p*P+i)*2*B +: 2*B] = {4'(r), 4'(m)};
        acc_p[p][a] += r + 8 + m;
        acc_m[p][a] += r + 8 - m;
      end
      if (pos == L*NA - 1) begin
        pend_p = acc_p;
        pend_m = acc_m;
        pend_bank = wb;
        wb = ~wb;
        sw_at = cyc + 3;
        pos = 0;
      end else pos++;
    end
  endtask
  task automatic rstep(input bit s);
    step(s, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
         int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
  endtask
  task automatic run(input int n);
    repeat (n) rstep(0);
  endtask
  task automatic req(input int aa, input int pa, input int ab, input int pb);
    step(0, 1, aa, pa, ab, pb);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end
  initial begin
    rst_n = 0;
    sync = 0;
    req_vld = 0;
    din = '0;
    req_ant_a = 0;
    req_ant_b = 0;
    req_pol_a = 0;
    req_pol_b = 0;
    rst_v = 0;
    rnd = 0;
    clr_pat();
    repeat (3) rstep(0);
    rst_v = 1;
    rstep(0);
    rstep(1);
    run(16);
    fre[0][2] = -5; fim[0][2] = 2; fre[0][1] = -8; fim[0][1] = -1;
    repeat (3) req(1, 0, 2, 1);
    run(13);
    clr_pat();
    fre[1][0] = 7; fim[1][0] = -8; fre[0][3] = -8; fim[0][3] = 7;
    repeat (3) req(1, 0, 2, 0);
    run(13);
    rnd = 1;
    repeat (3) req(0, 1, 3, 0);
    run(7);
    rstep(1);
    repeat (2) req(0, 0, 1, 1);
    run(22);
    run(5);
    rst_v = 0;
    repeat (3) req(1, 0, 2, 1);
    rst_v = 1;
    rstep(0);
    rstep(1);
    rnd = 0;
    clr_pat();
    run(16);
    repeat (3) req(1, 0, 2, 1);
    rnd = 1;
    run(48);
    repeat (LAT + 2) step(0, 0, 0, 0, 0, 0);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/component_tracker_mp.md
Name: component_tracker_mp

Overview:
- Multi-polarisation, parametrised successor to the single-pol X-engine component tracker.
- Per antenna and per polarisation, it accumulates the serial sums S+ = sum(re_u + im) and S- = sum(re_u - im) over one accumulation window. re_u is the offset-binary real part, converted internally from signed.
- Results are double-buffered. Per-baseline re/im correction terms, including cross-pol pairs, are served on a request port. The X-engine output stage uses these terms to remove the offset-binary bias.

Parameters:
- SERIAL_ACC_LEN_BITS, 7: serial accumulation length per antenna is 2^this (L).
- P_FACTOR_BITS, 2: parallel samples per clock per pol is 2^this (P).
- BITWIDTH, 4: width of each signed re/im part (B).
- N_ANTS, 32: antennas per window.
- N_POLS, 2: polarisations, 1..4.
- Derived widths:
  - ADD_W = P_FACTOR_BITS+B
  - SUM_W = ADD_W+2
  - ACC_W = SUM_W+SERIAL_ACC_LEN_BITS
  - CORR_W = ACC_W+1
  - AB = log2(N_ANTS)
  - PB = max(1, log2(N_POLS))

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- sync  in  1  window-start pulse
- din  in  N_POLS*P*2*B  samples. Pol p, sample i occupies slice (p*P+i). re is the upper B bits of the slice, im the lower B bits. Both are two's complement.
- req_vld  in  1  correction request strobe
- req_ant_a, req_ant_b  in  AB each  baseline antennas
- req_pol_a, req_pol_b  in  PB each  baseline pols
- corr_vld  out  1  correction valid
- re_corr, im_corr  out  CORR_W each  signed corrections
- rd_bank  out  1  bank currently served
- bank_vld  out  1  rd_bank holds a complete window
- window_done  out  1  one-cycle pulse at each bank switch

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs go to 0.
  - Antenna/sample counters and partial sums are cleared; write bank = 0.
  - Request pipeline is flushed.
  - Memory contents are don't-care, but bank_vld=0 guards them.
- Input order: sync high at cycle t makes din at t+1 the first sample of ant 0. The order is ant 0 for L cycles, then ant 1, ..., then ant N_ANTS-1; after that it wraps to ant 0 into the other bank. Windows run back-to-back without a further sync.
- Ingest pipeline:
  - re_u = re with MSB inverted (unsigned).
  - Registered adder tree per pol: re_sum is ADD_W unsigned, im_sum is ADD_W signed.
  - s+ = {0,re_sum}+im_sum and s- = {0,re_sum}-im_sum, each SUM_W signed. Exact, no saturation.
  - Accumulators are ACC_W signed. Each antenna's first sample loads the accumulator; later samples add to it.
  - On the L-th sample, both sums for every pol are written to memory[wr_bank][pol][ant].
- Bank switch:
  - If the L-th sample of ant N_ANTS-1 is at cycle t, then at t+3: rd_bank <= old wr_bank, bank_vld <= 1, window_done = 1 for one cycle, and wr_bank toggles for the next window.
- sync mid-window:
  - Partial accumulation is discarded; counters restart; wr_bank <= 0.
  - bank_vld <= 0 and rd_bank <= 0 the following cycle.
- sync coincident with a window end: sync wins; no bank switch and no window_done.
- Requests (fully pipelined, one per cycle, no backpressure):
  - Request accepted at cycle t gives a response at t+2.
  - re_corr = S+[pol_a][ant_a] + S+[pol_b][ant_b]
  - im_corr = S-[pol_b][ant_b] - S-[pol_a][ant_a]
  - Both results are sign-extended to CORR_W before the add/subtract, so they are exact.
  - The bank is latched at t; a switch during t+1..t+2 does not affect an in-flight request.
  - corr_vld at t+2 = req_vld & bank_vld, both sampled at t. When corr_vld=0, re_corr and im_corr are 0.
  - ant_a = ant_b with pol_a = pol_b is legal (autocorrelation): re_corr = 2*S+, im_corr = 0.
  - A pol index >= N_POLS returns 0 sums for that operand.
- Memory: two read ports (a and b), one write port. Inferred as distributed RAM or duplicated BRAM.

Optional Feature:
- Macro: COMPONENT_TRACKER_MP_DOUT_REG_EN.
- When defined: an extra output register stage is added. Request-to-corr_vld latency becomes 3; all other behaviour is unchanged.
- When undefined: latency is 2.

Test Plan:
- Common configuration: L=4, P=2, B=4, N_ANTS=4, N_POLS=2.
- Constant re=0, im=0 (so re_u=8) on all ants/pols, one full window -> window_done at the expected cycle, bank_vld=1, rd_bank=0. Request (1,0)/(2,1) -> re_corr=128, im_corr=0 at t+2.
- Ant2 pol0 re=-5, im=2 and ant1 pol0 re=-8, im=-1 -> S+ = 40 and -8, S- = 8 and 8. Request a=1, b=2, pol0/pol0 -> re_corr=32, im_corr=0.
- Extremes: ant0 pol1 re=7, im=-8 and ant3 pol0 re=-8, im=7 -> S+ = 56 and 56, S- = 184 and -56. Request a=(0,p1), b=(3,p0) -> re_corr=112, im_corr=-240, with no wrap.
- sync halfway through ant2 of window 2 -> bank_vld=0 the following cycle. Requests return corr_vld=0 with zero data. The next full window completes into bank 0.
- rst_n=0 mid-window with req_vld held high -> all outputs 0 from the next cycle. After release and sync, the first window behaves exactly as in scenario 1.
- Requests issued in the 2 cycles before a bank switch -> data from the old bank; the request issued at the switch cycle -> data from the new bank. Repeat with COMPONENT_TRACKER_MP_DOUT_REG_EN and check latency 3.
